seq_detect_param: RTL

//  Parametrised Moore serial-pattern detector: next generation of the fixed 1011 FSM.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/sat_counter.sv | 28 ++
 rtl/seq_detect_param.sv | 100 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
// Holds the FSM state encoding, the overlap-mode constants and the
// legal pattern-length range together with its check function.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_HIT  = 2'd2
  } state_e;

  localparam logic OVL_OFF = 1'b0;  // non-overlapping: a match consumes its bits
  localparam logic OVL_ON  = 1'b1;  // overlapping: any valid bit may end a match

  localparam int SEQ_LEN_MIN = 2;
  localparam int SEQ_LEN_MAX = 16;

  function automatic bit seq_len_ok(input int n);
    return (n >= SEQ_LEN_MIN) && (n <= SEQ_LEN_MAX);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Ports: clk_i/rst_ni clock and async active-low reset, inc_i count request,
//        clr_i synchronous clear, cnt_o current count (holds at all-ones).
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector with reloadable pattern,
// per-match overlap selection, input valid strobe and saturating match count.
// Ports: clk_i/rst_ni clock + async active-low reset; en_i enable; in_i/in_vld_i
//        serial bit and qualifier; ovl_i overlap mode; pat_ld_i/pat_in_i pattern
//        reload (MSB first); cnt_clr_i count clear; out_o match flag; cnt_o count.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN  = 4,
  parameter logic [SEQ_LEN-1:0] SEQ_INIT = 4'b1011,
  parameter int                 CNT_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               in_i,
  input  logic               in_vld_i,
  input  logic               ovl_i,
  input  logic               pat_ld_i,
  input  logic [SEQ_LEN-1:0] pat_in_i,
  input  logic               cnt_clr_i,
  output logic               out_o,
  output logic [CNT_W-1:0]   cnt_o
);

  if (!seq_len_ok(SEQ_LEN)) begin : g_bad_seq_len
    $error("seq_detect_param: SEQ_LEN must be within 2..16");
  end

  // Fill counts 0..SEQ_LEN, so it needs one more code than the pattern width.
  localparam int              FW        = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0]   FILL_FULL = FW'(SEQ_LEN);

  state_e             state_q;
  logic [SEQ_LEN-1:0] shift_q;
  logic [SEQ_LEN-1:0] pat_q;
  logic [FW-1:0]      fill_q;

  logic [SEQ_LEN-1:0] shift_d;
  logic [FW-1:0]      fill_d;
  logic               match;

  // History as it would look after accepting in_i on this edge.
  always_comb begin
    shift_d = {shift_q[SEQ_LEN-2:0], in_i};
    fill_d  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
  end

  // A reload on the same edge discards the incoming bit, so it also kills the match.
  assign match = en_i & in_vld_i & ~pat_ld_i & (fill_d == FILL_FULL) & (shift_d == pat_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      fill_q  <= '0;
      pat_q   <= SEQ_INIT;
    end else begin
      // Reload is honoured whether or not the detector is enabled.
      if (pat_ld_i) begin
        pat_q <= pat_in_i;
      end

      if (!en_i) begin
        state_q <= ST_IDLE;
        shift_q <= '0;
        fill_q  <= '0;
      end else if (pat_ld_i) begin
        fill_q  <= '0;
        state_q <= ST_HUNT;
      end else if (in_vld_i) begin
        shift_q <= shift_d;
        if (match) begin
          state_q <= ST_HIT;
          fill_q  <= (ovl_i == OVL_ON) ? FILL_FULL : '0;
        end else begin
          state_q <= ST_HUNT;
          fill_q  <= fill_d;
        end
      end else begin
        // No bit this cycle: history frozen, but a hit lasts only one cycle.
        state_q <= ST_HUNT;
      end
    end
  end

  // Decode of the state register only; no path from in_i.
  assign out_o = (state_q == ST_HIT);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (match),
    .clr_i (cnt_clr_i),
    .cnt_o (cnt_o)
  );

endmodule
